dnc_temporal_link_stream: RTL and testbench
===========================================

// Module: dnc_temporal_link_stream
// PURPOSE
//  Streaming, fixed-point DNC temporal link matrix update for the memory unit, parametrised in size:
//  L(t)[g][j] = (1 - w[g] - w[j])*L(t-1)[g][j] + w[g]*p(t-1)[j], with L[g][g] = 0.
//  Buffers the write weighting w and precedence p (N <= N_MAX), then streams L row-major with a 2-cycle pipeline.
//  Feeds read-weighting forward/backward computation; runtime N, saturating arithmetic, error reporting.
// PARAMETERS
//  DATA_SIZE     32  signed fixed-point word width
//  FRAC_SIZE     16  fraction bits (ONE = 1<<FRAC_SIZE)
//  CONTROL_SIZE  8   index/size width
//  N_MAX         16  w/p buffer depth, max runtime N
// PORTS
//  CLK            in   1             clock, rising edge
//  RST            in   1             synchronous reset, active-high
//  START          in   1             start one update (sampled in IDLE only)
//  READY          out  1             1-cycle completion pulse
//  BUSY           out  1             high from START accept until READY
//  ERROR          out  1             1-cycle pulse with READY on illegal SIZE_N_IN
//  SIZE_N_IN      in   CONTROL_SIZE  N, sampled with START
//  W_IN_ENABLE    in   1             w[j] valid, j auto-increments
//  W_IN           in   DATA_SIZE     w element
//  P_IN_ENABLE    in   1             p[j] valid, j auto-increments
//  P_IN           in   DATA_SIZE     p(t-1) element
//  L_IN_READY     out  1             high in MATRIX state only
//  L_IN_ENABLE    in   1             L(t-1)[g][j] valid (row-major)
//  L_IN           in   DATA_SIZE     L(t-1) element
//  L_OUT_ENABLE   out  1             L_OUT valid
//  L_OUT_G        out  CONTROL_SIZE  row index of L_OUT
//  L_OUT_J        out  CONTROL_SIZE  column index of L_OUT
//  L_OUT          out  DATA_SIZE     L(t)[g][j]
//  P_OUT_ENABLE   out  1             (DNC_TLM_PRECEDENCE_EN only) P_OUT valid
//  P_OUT          out  DATA_SIZE     (DNC_TLM_PRECEDENCE_EN only) p(t)[j]
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE; counters 0. Buffers not cleared. RST mid-operation aborts; no READY.
//  FSM: IDLE -START-> CHECK -> (N==0 | N>N_MAX: DONE with ERROR) | LOAD.
//  LOAD -(N w and N p accepted)-> MATRIX -(N*N L accepted)-> DRAIN -(pipeline empty)-> DONE -> IDLE.
//  DONE asserts READY for 1 cycle, then IDLE. START outside IDLE is ignored.
//  LOAD: W and P use independent counters and may arrive in the same cycle. Enables beyond N are ignored.
//  L_IN_ENABLE outside MATRIX is ignored (L_IN_READY=0).
//  MATRIX: each accepted L_IN uses counters g,j (j fastest). Output follows 2 cycles later with its g,j.
//  Gaps in L_IN_ENABLE are allowed; output order equals input order.
//  Stage1: c = ONE - w[g] - w[j] (DATA_SIZE+2 bits); q = w[g]*p[j] >>> FRAC_SIZE.
//  Stage2: L_OUT = sat(c*L_IN >>> FRAC_SIZE + q). Products are full width, arithmetic shift truncates.
//  Saturation clamps to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
//  g==j: L_OUT = 0 regardless of inputs. L_OUT holds its last value when L_OUT_ENABLE=0.
//  READY: the cycle after the last L_OUT_ENABLE (N=1: after the single diagonal 0 is emitted).
// CONFIGURATION
//  DNC_TLM_PRECEDENCE_EN defined: adds P_OUT/P_OUT_ENABLE.
//    LOAD accumulates s = sum w (saturating).
//    While g==0 in MATRIX, the block emits p(t)[j] = sat((ONE - s)*p[j] >>> FRAC_SIZE + w[j]), aligned with L_OUT for (0,j).
//  Undefined: ports absent, no accumulator, L behaviour identical.
// STRUCTURE
//  Package dnc_tlm_pkg: state enum (IDLE, CHECK, LOAD, MATRIX, DRAIN, DONE), ONE_FIX, sat_fix() function.
//  Sub-module dnc_tlm_mac: 2-stage saturating fixed-point multiply-add, used for L (and for p when DNC_TLM_PRECEDENCE_EN is defined).
// TESTING (Q16.16, ONE=0x00010000, N_MAX=16)
//  1 N=2, w=[0x8000,0x4000], p=[0x4000,0x8000], L=0 -> L_OUT (0,0)=0, (0,1)=0x4000, (1,0)=0x1000, (1,1)=0; READY next cycle.
//  2 N=2, w=[0x4000,0x4000], p=0, L(0,1)=0x10000 -> L_OUT(0,1)=0x8000; diagonals 0 for any L_IN.
//  3 N=2, w=[0xFFFF0000,0xFFFF0000], L(0,1)=0x40000000 -> L_OUT(0,1)=0x7FFFFFFF (saturated).
//  4 SIZE_N_IN=0 and then 17 -> READY=ERROR=1 for 1 cycle, BUSY drops, no L_OUT_ENABLE; L_IN_ENABLE bursts ignored.
//  5 N=3 with 1-cycle gaps in L_IN_ENABLE, RST asserted after 4th element -> next cycle all outputs 0;
//    a new START then completes normally with 9 outputs.
//  6 DNC_TLM_PRECEDENCE_EN defined, stimulus of test 1 -> P_OUT=0x9000 then 0x6000, aligned with (0,0),(0,1).

Source files
------------

// File: rtl/dnc_temporal_link_stream_pkg.sv
// Shared FSM state type, Q-format constant and saturation helper for the temporal link stream.
package dnc_tlm_pkg;

   typedef enum logic [2:0] {IDLE, CHECK, LOAD, MATRIX, DRAIN, DONE} state_t;

   localparam logic signed [31:0] ONE_FIX = 32'sh0001_0000;
   localparam int SAT_W = 128;

   // Clamps x to the signed range of a dw-bit word; callers truncate the result to dw bits.
   function automatic logic signed [SAT_W-1:0] sat_fix(input logic signed [SAT_W-1:0] x, input int dw);
      logic signed [SAT_W-1:0] mx;
      mx = '0;
      for (int i = 0; i < SAT_W; i++) mx[i] = (i < dw - 1);
      if (x > mx) return mx;
      if (x < ~mx) return ~mx;
      return x;
   endfunction

endpackage

// File: rtl/dnc_temporal_link_stream_if.sv
// Control, w/p load, L(t-1) input and L(t) output bundle; p(t) port exists only with DNC_TLM_PRECEDENCE_EN.
interface dnc_temporal_link_stream_if #(parameter int DATA_SIZE = 32, parameter int CONTROL_SIZE = 8);
   logic                           start, ready, busy, error;
   logic [CONTROL_SIZE-1:0]        size_n_in;
   logic                           w_in_enable, p_in_enable;
   logic signed [DATA_SIZE-1:0]    w_in, p_in;
   logic                           l_in_ready, l_in_enable;
   logic signed [DATA_SIZE-1:0]    l_in;
   logic                           l_out_enable;
   logic [CONTROL_SIZE-1:0]        l_out_g, l_out_j;
   logic signed [DATA_SIZE-1:0]    l_out;
`ifdef DNC_TLM_PRECEDENCE_EN
   logic                           p_out_enable;
   logic signed [DATA_SIZE-1:0]    p_out;
   modport master (output start, size_n_in, w_in_enable, w_in, p_in_enable, p_in, l_in_enable, l_in,
                   input ready, busy, error, l_in_ready, l_out_enable, l_out_g, l_out_j, l_out,
                   p_out_enable, p_out);
   modport slave  (input start, size_n_in, w_in_enable, w_in, p_in_enable, p_in, l_in_enable, l_in,
                   output ready, busy, error, l_in_ready, l_out_enable, l_out_g, l_out_j, l_out,
                   p_out_enable, p_out);
`else
   modport master (output start, size_n_in, w_in_enable, w_in, p_in_enable, p_in, l_in_enable, l_in,
                   input ready, busy, error, l_in_ready, l_out_enable, l_out_g, l_out_j, l_out);
   modport slave  (input start, size_n_in, w_in_enable, w_in, p_in_enable, p_in, l_in_enable, l_in,
                   output ready, busy, error, l_in_ready, l_out_enable, l_out_g, l_out_j, l_out);
`endif
endinterface

// File: rtl/dnc_temporal_link_stream_mac.sv
// out = sat((ONE - a - b) * x >>> F + (m1 * m2 >>> F)), forced 0 when zero; 2-cycle latency, no stall.
module dnc_tlm_mac
   import dnc_tlm_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int FRAC_SIZE = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_vld,
   input  logic                        zero,
   input  logic signed [DATA_SIZE-1:0] a,
   input  logic signed [DATA_SIZE-1:0] b,
   input  logic signed [DATA_SIZE-1:0] m1,
   input  logic signed [DATA_SIZE-1:0] m2,
   input  logic signed [DATA_SIZE-1:0] x,
   output logic                        out_vld,
   output logic signed [DATA_SIZE-1:0] out
);
   localparam int CW = DATA_SIZE + 2;
   localparam int PW = 2 * DATA_SIZE;
   localparam int XW = CW + DATA_SIZE;
   localparam logic signed [CW-1:0] ONE = CW'(1) <<< FRAC_SIZE;

   logic signed [CW-1:0]        c_d, c_q;
   logic signed [PW-1:0]        prod, q_q;
   logic signed [DATA_SIZE-1:0] x_q;
   logic                        vld_q, zero_q;
   logic signed [XW-1:0]        cx;
   logic signed [SAT_W-1:0]     sum, sat;

   always_comb begin
      c_d  = ONE - CW'(a) - CW'(b);
      prod = PW'(m1) * PW'(m2);
      cx   = XW'(c_q) * XW'(x_q);
      sum  = SAT_W'(cx >>> FRAC_SIZE) + SAT_W'(q_q);
      sat  = sat_fix(sum, DATA_SIZE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= 1'b0;
         zero_q  <= 1'b0;
         c_q     <= '0;
         q_q     <= '0;
         x_q     <= '0;
         out_vld <= 1'b0;
         out     <= '0;
      end else begin
         vld_q   <= in_vld;
         if (in_vld) begin
            c_q    <= c_d;
            q_q    <= prod >>> FRAC_SIZE;
            x_q    <= x;
            zero_q <= zero;
         end
         out_vld <= vld_q;
         if (vld_q) out <= zero_q ? '0 : DATA_SIZE'(sat);
      end
   end
endmodule

// File: rtl/dnc_temporal_link_stream.sv
// Buffers w/p then streams L(t) row-major, 2 cycles behind each accepted L(t-1); L_IN_READY only in MATRIX.
// Optional p(t) output on row 0 under DNC_TLM_PRECEDENCE_EN.
module dnc_temporal_link_stream
   import dnc_tlm_pkg::*;
#(
   parameter int DATA_SIZE    = 32,
   parameter int FRAC_SIZE    = 16,
   parameter int CONTROL_SIZE = 8,
   parameter int N_MAX        = 16
) (
   input logic                       clk,
   input logic                       rst,
   dnc_temporal_link_stream_if.slave bus
);
   localparam int IW = $clog2(N_MAX);
   localparam logic [CONTROL_SIZE-1:0] C1 = CONTROL_SIZE'(1);

   state_t                      state, state_d;
   logic [CONTROL_SIZE-1:0]     n, nm1, wcnt, pcnt, g, j, t1_g, t1_j;
   logic                        err, bad_n, w_acc, p_acc, l_acc, last_l, t1_vld;
   logic signed [DATA_SIZE-1:0] w_buf [N_MAX];
   logic signed [DATA_SIZE-1:0] p_buf [N_MAX];
   logic signed [DATA_SIZE-1:0] wg, wj, pj;

   assign nm1    = n - C1;
   assign bad_n  = (n == '0) || (n > CONTROL_SIZE'(N_MAX));
   assign w_acc  = (state == LOAD) && bus.w_in_enable && (wcnt < n);
   assign p_acc  = (state == LOAD) && bus.p_in_enable && (pcnt < n);
   assign l_acc  = (state == MATRIX) && bus.l_in_enable;
   assign last_l = (g == nm1) && (j == nm1);
   assign wg     = w_buf[g[IW-1:0]];
   assign wj     = w_buf[j[IW-1:0]];
   assign pj     = p_buf[j[IW-1:0]];

   always_comb begin
      state_d        = state;
      bus.ready      = 1'b0;
      bus.busy       = 1'b0;
      bus.error      = 1'b0;
      bus.l_in_ready = 1'b0;
      case (state)
         IDLE:   if (bus.start) state_d = CHECK;
         CHECK:  begin bus.busy = 1'b1; state_d = bad_n ? DONE : LOAD; end
         LOAD:   begin bus.busy = 1'b1; if (wcnt == n && pcnt == n) state_d = MATRIX; end
         MATRIX: begin
            bus.busy       = 1'b1;
            bus.l_in_ready = 1'b1;
            if (l_acc && last_l) state_d = DRAIN;
         end
         DRAIN:  begin bus.busy = 1'b1; if (!t1_vld) state_d = DONE; end
         DONE:   begin bus.ready = 1'b1; bus.error = err; state_d = IDLE; end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         n           <= '0;
         wcnt        <= '0;
         pcnt        <= '0;
         g           <= '0;
         j           <= '0;
         err         <= 1'b0;
         t1_vld      <= 1'b0;
         t1_g        <= '0;
         t1_j        <= '0;
         bus.l_out_g <= '0;
         bus.l_out_j <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE && bus.start) begin
            n    <= bus.size_n_in;
            wcnt <= '0;
            pcnt <= '0;
            g    <= '0;
            j    <= '0;
         end
         if (state == CHECK) err <= bad_n;
         if (w_acc) wcnt <= wcnt + C1;
         if (p_acc) pcnt <= pcnt + C1;
         if (l_acc) begin
            if (j == nm1) begin
               j <= '0;
               g <= g + C1;
            end else begin
               j <= j + C1;
            end
         end
         // Index tags ride alongside the MAC pipeline so L_OUT_G/J line up with L_OUT.
         t1_vld <= l_acc;
         if (l_acc) begin
            t1_g <= g;
            t1_j <= j;
         end
         if (t1_vld) begin
            bus.l_out_g <= t1_g;
            bus.l_out_j <= t1_j;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) w_buf[wcnt[IW-1:0]] <= bus.w_in;
      if (p_acc) p_buf[pcnt[IW-1:0]] <= bus.p_in;
   end

   dnc_tlm_mac #(.DATA_SIZE(DATA_SIZE), .FRAC_SIZE(FRAC_SIZE)) u_l_mac (
      .clk(clk), .rst(rst), .in_vld(l_acc), .zero(g == j),
      .a(wg), .b(wj), .m1(wg), .m2(pj), .x(bus.l_in),
      .out_vld(bus.l_out_enable), .out(bus.l_out)
   );

`ifdef DNC_TLM_PRECEDENCE_EN
   localparam logic signed [DATA_SIZE-1:0] ONE_D = DATA_SIZE'(1) <<< FRAC_SIZE;
   logic signed [DATA_SIZE-1:0] s;
   logic signed [SAT_W-1:0]     s_sum;

   always_comb s_sum = sat_fix(SAT_W'(s) + SAT_W'(bus.w_in), DATA_SIZE);

   always_ff @(posedge clk) begin
      if (rst) s <= '0;
      else if (state == IDLE && bus.start) s <= '0;
      else if (w_acc) s <= DATA_SIZE'(s_sum);
   end

   // p(t)[j] = (ONE - s) * p[j] + w[j] * ONE, issued alongside row 0.
   dnc_tlm_mac #(.DATA_SIZE(DATA_SIZE), .FRAC_SIZE(FRAC_SIZE)) u_p_mac (
      .clk(clk), .rst(rst), .in_vld(l_acc && (g == '0)), .zero(1'b0),
      .a(s), .b('0), .m1(wj), .m2(ONE_D), .x(pj),
      .out_vld(bus.p_out_enable), .out(bus.p_out)
   );
`endif
endmodule

// File: tb/tb_dnc_temporal_link_stream.sv
// Directed bench for the temporal link stream: known Q16.16 vectors, error sizes, mid-run reset.
module tb_dnc_temporal_link_stream;
   import dnc_tlm_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dnc_temporal_link_stream_if #(.DATA_SIZE(32), .CONTROL_SIZE(8)) bus ();

   dnc_temporal_link_stream #(.DATA_SIZE(32), .FRAC_SIZE(16), .CONTROL_SIZE(8), .N_MAX(16)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_out_cyc = -1;
   int cap_n = 0;
   int base  = 0;
   logic [31:0] cap_l [512];
   logic [7:0]  cap_g [512];
   logic [7:0]  cap_j [512];
   logic [31:0] wv [16];
   logic [31:0] pv [16];
   logic [31:0] lv [256];
   logic [31:0] ev [256];
   bit ok;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.l_out_enable && cap_n < 512) begin
         cap_l[cap_n] = bus.l_out;
         cap_g[cap_n] = bus.l_out_g;
         cap_j[cap_n] = bus.l_out_j;
         cap_n++;
         last_out_cyc = cyc;
      end
   end

`ifdef DNC_TLM_PRECEDENCE_EN
   int pcap_n = 0;
   logic [31:0] pcap [64];
   logic [15:0] pcap_tag [64];
   always @(negedge clk) begin
      if (bus.p_out_enable && pcap_n < 64) begin
         pcap[pcap_n]     = bus.p_out;
         pcap_tag[pcap_n] = bus.l_out_enable ? {bus.l_out_g, bus.l_out_j} : 16'hFFFF;
         pcap_n++;
      end
   end
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input int n);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.size_n_in = n[7:0];
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   task automatic load(input int n, input bit extra);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.w_in_enable = 1'b1; bus.w_in = wv[i];
         bus.p_in_enable = 1'b1; bus.p_in = pv[i];
      end
      if (extra) begin
         @(negedge clk);
         bus.w_in = 32'h7FFF0000;
         bus.p_in = 32'h7FFF0000;
      end
      @(negedge clk);
      bus.w_in_enable = 1'b0;
      bus.p_in_enable = 1'b0;
   endtask

   task automatic stream_l(input int cnt, input bit gap);
      bit seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.l_in_ready) begin seen = 1'b1; break; end
      end
      chk("l_in_ready_wait", 32'(seen), 32'd1);
      for (int k = 0; k < cnt; k++) begin
         bus.l_in_enable = 1'b1;
         bus.l_in        = lv[k];
         @(negedge clk);
         if (gap) begin
            bus.l_in_enable = 1'b0;
            @(negedge clk);
         end
      end
      bus.l_in_enable = 1'b0;
   endtask

   task automatic wait_ready(output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (bus.ready) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      chk("ready_timeout", 32'(seen), 32'd1);
   endtask

   task automatic check_run(input string t, input int n);
      chk($sformatf("%s_count", t), 32'(cap_n - base), 32'(n * n));
      for (int k = 0; k < n * n; k++) begin
         chk($sformatf("%s_l%0d", t, k), cap_l[base + k], ev[k]);
         chk($sformatf("%s_g%0d", t, k), 32'(cap_g[base + k]), 32'(k / n));
         chk($sformatf("%s_j%0d", t, k), 32'(cap_j[base + k]), 32'(k % n));
      end
   endtask

   task automatic finish_normal(input string t);
      wait_ready(ok);
      chk($sformatf("%s_error", t), 32'(bus.error), 32'd0);
      chk($sformatf("%s_busy_at_ready", t), 32'(bus.busy), 32'd0);
      chk($sformatf("%s_ready_lat", t), 32'(cyc - last_out_cyc), 32'd1);
      @(negedge clk);
      chk($sformatf("%s_ready_pulse", t), 32'(bus.ready), 32'd0);
   endtask

   initial begin
      bus.start = 1'b0; bus.size_n_in = '0;
      bus.w_in_enable = 1'b0; bus.w_in = '0;
      bus.p_in_enable = 1'b0; bus.p_in = '0;
      bus.l_in_enable = 1'b0; bus.l_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      chk("rst_l_in_ready", 32'(bus.l_in_ready), 32'd0);
      chk("rst_l_out_enable", 32'(bus.l_out_enable), 32'd0);
      chk("rst_l_out", bus.l_out, 32'd0);
      chk("rst_l_out_g", 32'(bus.l_out_g), 32'd0);
      chk("rst_l_out_j", 32'(bus.l_out_j), 32'd0);
      rst = 1'b0;

      // 1: basic N=2, L=0, extra w/p enable past N must be ignored
      wv[0] = 32'h8000; wv[1] = 32'h4000;
      pv[0] = 32'h4000; pv[1] = 32'h8000;
      for (int k = 0; k < 4; k++) lv[k] = 32'h0;
      ev[0] = 32'h0; ev[1] = 32'h4000; ev[2] = 32'h1000; ev[3] = 32'h0;
      base = cap_n;
      start_op(2);
      chk("t1_busy_after_start", 32'(bus.busy), 32'd1);
      load(2, 1'b1);
      stream_l(4, 1'b0);
      finish_normal("t1");
      check_run("t1", 2);
`ifdef DNC_TLM_PRECEDENCE_EN
      chk("t6_p_count", 32'(pcap_n), 32'd2);
      chk("t6_p0", pcap[0], 32'h9000);
      chk("t6_p1", pcap[1], 32'h6000);
      chk("t6_p0_align", 32'(pcap_tag[0]), 32'h0000);
      chk("t6_p1_align", 32'(pcap_tag[1]), 32'h0001);
`endif

      // 2: retention term, diagonals forced to zero
      wv[0] = 32'h4000; wv[1] = 32'h4000;
      pv[0] = 32'h0;    pv[1] = 32'h0;
      lv[0] = 32'h12345; lv[1] = 32'h10000; lv[2] = 32'h800; lv[3] = 32'h7FFFFFFF;
      ev[0] = 32'h0; ev[1] = 32'h8000; ev[2] = 32'h400; ev[3] = 32'h0;
      base = cap_n;
      start_op(2);
      load(2, 1'b0);
      stream_l(4, 1'b0);
      finish_normal("t2");
      check_run("t2", 2);

      // 3: positive and negative saturation
      wv[0] = 32'hFFFF0000; wv[1] = 32'hFFFF0000;
      pv[0] = 32'h0;        pv[1] = 32'h0;
      lv[0] = 32'h0; lv[1] = 32'h40000000; lv[2] = 32'hC0000000; lv[3] = 32'h0;
      ev[0] = 32'h0; ev[1] = 32'h7FFFFFFF; ev[2] = 32'h80000000; ev[3] = 32'h0;
      base = cap_n;
      start_op(2);
      load(2, 1'b0);
      stream_l(4, 1'b0);
      finish_normal("t3");
      check_run("t3", 2);

      // 4: illegal sizes with L_IN_ENABLE held high throughout
      for (int s = 0; s < 2; s++) begin
         base = cap_n;
         bus.l_in_enable = 1'b1;
         bus.l_in = 32'h1234_5678;
         start_op(s == 0 ? 0 : 17);
         chk($sformatf("t4_%0d_l_in_ready", s), 32'(bus.l_in_ready), 32'd0);
         wait_ready(ok);
         chk($sformatf("t4_%0d_error", s), 32'(bus.error), 32'd1);
         chk($sformatf("t4_%0d_busy", s), 32'(bus.busy), 32'd0);
         @(negedge clk);
         bus.l_in_enable = 1'b0;
         chk($sformatf("t4_%0d_ready_pulse", s), 32'(bus.ready), 32'd0);
         chk($sformatf("t4_%0d_error_pulse", s), 32'(bus.error), 32'd0);
         chk($sformatf("t4_%0d_no_l_out", s), 32'(cap_n - base), 32'd0);
      end

      // 5: N=3 with gaps, reset after 4th element, then a clean rerun
      wv[0] = 32'h4000;  wv[1] = 32'h2000; wv[2] = 32'h0;
      pv[0] = 32'h10000; pv[1] = 32'h0;    pv[2] = 32'h8000;
      for (int k = 0; k < 9; k++) lv[k] = 32'h10000;
      ev[0] = 32'h0;    ev[1] = 32'hA000; ev[2] = 32'hE000;
      ev[3] = 32'hC000; ev[4] = 32'h0;    ev[5] = 32'hF000;
      ev[6] = 32'hC000; ev[7] = 32'hE000; ev[8] = 32'h0;
      start_op(3);
      load(3, 1'b0);
      stream_l(4, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_l_out_enable", 32'(bus.l_out_enable), 32'd0);
      chk("t5_rst_l_out", bus.l_out, 32'd0);
      chk("t5_rst_l_out_g", 32'(bus.l_out_g), 32'd0);
      chk("t5_rst_l_out_j", 32'(bus.l_out_j), 32'd0);
      chk("t5_rst_busy", 32'(bus.busy), 32'd0);
      chk("t5_rst_ready", 32'(bus.ready), 32'd0);
      chk("t5_rst_l_in_ready", 32'(bus.l_in_ready), 32'd0);
      rst = 1'b0;
      base = cap_n;
      start_op(3);
      load(3, 1'b0);
      stream_l(9, 1'b1);
      finish_normal("t5");
      check_run("t5", 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
